multi_issue_pipe_reg: RTL
=========================

# multi_issue_pipe_reg

Parametrised N-lane pipeline boundary register with valid/ready handshake, optional skid buffer, flush, and partial "keep-oldest-k" lane kill. It is the next generation of the hand-written ID/EX, EX/D$ and MEM/WB registers in the dual-issue core. It generalises their stall/flush/exception-squash behaviour to arbitrary issue width and payload. It sits between any two pipeline stages, with lane 0 the oldest instruction in program order.

## Interface
- LANES, 2: issue width; lane 0 oldest.
- WIDTH, 32: payload bits per lane.
- SKID, 1: 1 = two-entry (main + skid) with registered in_ready; 0 = single-entry with combinational in_ready.
- CNT_W, 16: width of the performance counters.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  LANES  per-lane valid of the incoming group.
- in_data  in  LANES×WIDTH  per-lane payload.
- in_ready  out  1  group accepted when in_ready && |in_valid.
- out_valid  out  LANES  per-lane valid of the held group, after kill masking.
- out_data  out  LANES×WIDTH  held payload.
- out_ready  in  1  downstream consumes the group when out_ready && |out_valid.
- flush  in  1  discard everything held plus the input this cycle.
- kill_valid  in  1  exception squash request.
- kill_keep  in  $clog2(LANES+1)  number of oldest lanes of the output group that survive.
- stall_cnt  out  CNT_W  cycles with held group valid and ~out_ready; saturating.
- kill_cnt  out  CNT_W  lanes squashed by kill; saturating.

## Operation
- Storage: main group (drives out_*). When SKID=1 there is also a skid group. Each group has LANES valid bits plus data.
- Combinational masks:
  - kmask[i] = kill_valid && i ≥ kill_keep.
  - out_valid[i] = main_v[i] && ~kmask[i].
  - kill_keep ≥ LANES means nothing is masked.
- Acceptance:
  - acc = in_ready && |in_valid && ~flush && ~kill_valid.
  - Input presented during a flush or kill is dropped, and upstream sees it consumed.
- SKID=1:
  - in_ready = ~skid_full, with no combinational path from out_ready.
  - If main is empty or consumed: main ← skid if skid is full, else input if acc, else empty. skid ← empty.
  - Else, if acc: skid ← input.
- SKID=0:
  - in_ready = ~|main_v || out_ready.
  - main ← input if acc, else empty if consumed.
- Kill at the edge:
  - Main lanes with kmask set are cleared. The skid group is cleared entirely, since it is younger.
  - Surviving lanes may be consumed in the same cycle.
  - A main group left all-invalid counts as empty.
- Flush has priority over kill, acceptance and consumption. Both groups are cleared at the edge. out_valid is not masked by flush in that cycle.
- Counter updates:
  - stall_cnt +1 when |out_valid && ~out_ready.
  - kill_cnt += popcount(main_v & kmask), plus popcount(skid_v) when the skid group is cleared by kill.
  - Both saturate at 2^CNT_W−1. Flush does not count.
- Invalid lanes carry don't-care data. Payload of valid lanes is never altered.

## Timing
- Reset (asynchronous, low): all valids 0, data 0, counters 0, in_ready = 1.
- Latency: accept at edge t, out_valid from t+1.
- Throughput: one group per cycle when out_ready is held high.
- SKID=1: after a single stall cycle, in_ready drops the next cycle. No group is ever lost.
- Combinational paths:
  - kill_valid/kill_keep → out_valid, always.
  - out_ready → in_ready, only when SKID=0.
- Reset asserted mid-transfer: state clears immediately, with no partial group.

## Structure
- Package cpu_defs: lane-count and counter-width localparams. The payload is an opaque WIDTH-bit vector so pipeline_*_t structs are packed by the instantiator.
- One natural sub-module, lane_group_reg: a valid+data group register with clear-mask and load. It is instantiated twice for main and skid.
- Popcount is an inline function, not a module.

## Test plan
- Streaming: LANES=2, SKID=1, out_ready=1. Feed groups A,B,C on consecutive cycles. out_data shows A,B,C at t+1..t+3, stall_cnt stays 0.
- Backpressure: hold out_ready=0 for 3 cycles while feeding A,B,C.
  - A is held, B goes to skid, in_ready drops, and C is retried.
  - On release, the order is A,B,C with no loss.
  - stall_cnt = 3.
- Partial kill: main={v=11, X0,X1}, kill_valid=1, kill_keep=1, out_ready=1. out_valid=01 that cycle, X0 is consumed, and kill_cnt = 1.
- Kill with skid: main=11, skid=11, out_ready=0, kill_keep=0. Both groups are cleared next cycle, kill_cnt = 4, in_ready = 1.
- Flush vs. kill and input: flush=1, kill_valid=1, and input valid in the same cycle. Next cycle all valids are 0, counters are unchanged, and the input is not delivered.
- SKID=0, LANES=4: out_ready toggling 1,0,1. in_ready follows ~|main_v || out_ready combinationally. Saturation check: force 70000 stall cycles with CNT_W=16, and stall_cnt = 65535.

Source files
------------

// File: rtl/multi_issue_pipe_reg_pkg.sv
// Shared definitions for the N-lane pipeline boundary register.
// Payload stays an opaque WIDTH-bit vector; instantiators pack their own
// pipeline_*_t structs into it.
package cpu_defs;

    localparam int unsigned DEF_LANES = 2;
    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_CNT_W = 16;

    // Where the main group is reloaded from at the next edge.
    typedef enum logic [1:0] {
        MAIN_HOLD      = 2'd0,
        MAIN_FROM_SKID = 2'd1,
        MAIN_FROM_IN   = 2'd2,
        MAIN_CLEAR     = 2'd3
    } main_src_e;

endpackage

// File: rtl/multi_issue_pipe_reg_lane_group_reg.sv
// One group of LANES valid bits plus payload. A load overwrites the whole
// group; otherwise lanes selected by clr_mask are invalidated and the payload
// is left untouched.
module lane_group_reg #(
    parameter int unsigned LANES = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [LANES-1:0]       load_v,
    input  logic [LANES*WIDTH-1:0] load_d,
    input  logic [LANES-1:0]       clr_mask,
    output logic [LANES-1:0]       q_v,
    output logic [LANES*WIDTH-1:0] q_d
);

    // Group storage: load wins over lane clearing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_v <= '0;
            q_d <= '0;
        end else if (load) begin
            q_v <= load_v;
            q_d <= load_d;
        end else begin
            q_v <= q_v & ~clr_mask;
        end
    end

endmodule

// File: rtl/multi_issue_pipe_reg.sv
// N-lane pipeline boundary register with valid/ready handshake, optional
// skid group, flush and keep-oldest-k lane kill. Lane 0 is the oldest.
module multi_issue_pipe_reg
    import cpu_defs::*;
#(
    parameter int unsigned LANES = DEF_LANES,
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SKID  = 1,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [LANES-1:0]           in_valid,
    input  logic [LANES*WIDTH-1:0]     in_data,
    output logic                       in_ready,
    output logic [LANES-1:0]           out_valid,
    output logic [LANES*WIDTH-1:0]     out_data,
    input  logic                       out_ready,
    input  logic                       flush,
    input  logic                       kill_valid,
    input  logic [$clog2(LANES+1)-1:0] kill_keep,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           kill_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic int unsigned popcount(input logic [LANES-1:0] v);
        int unsigned n = 0;
        for (int unsigned i = 0; i < LANES; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

    logic [LANES-1:0]       main_v;
    logic [LANES-1:0]       skid_v;
    logic [LANES-1:0]       kmask;
    logic [LANES*WIDTH-1:0] main_d;
    logic [LANES*WIDTH-1:0] skid_d;
    logic                   consumed;
    logic                   main_free;
    logic                   acc;
    main_src_e              main_src;
    logic                   main_load;
    logic [LANES-1:0]       main_load_v;
    logic [LANES*WIDTH-1:0] main_load_d;
    logic [LANES-1:0]       main_clr;
    logic                   skid_load;
    logic [LANES-1:0]       skid_clr;
    logic                   stall_inc;
    int unsigned            kill_inc;
    logic [CNT_W:0]         kill_sum;

    // Kill mask: every lane at or above kill_keep is squashed.
    always_comb begin
        kmask = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            kmask[i] = kill_valid && (i >= 32'(kill_keep));
        end
    end

    assign out_valid = main_v & ~kmask;
    assign out_data  = main_d;
    assign consumed  = out_ready && |out_valid;
    assign main_free = ~|main_v || consumed;
    assign in_ready  = (SKID != 0) ? ~|skid_v : (~|main_v || out_ready);
    assign acc       = in_ready && |in_valid && !flush && !kill_valid;

    // Next-state selection for main and skid groups; flush overrides all.
    // A kill always empties the skid (it is younger than anything in main),
    // so the skid is never promoted in a kill cycle.
    always_comb begin
        main_src  = MAIN_HOLD;
        skid_load = 1'b0;
        skid_clr  = '0;
        if (flush) begin
            main_src = MAIN_CLEAR;
            skid_clr = '1;
        end else if (SKID != 0) begin
            if (main_free) begin
                if (|skid_v && !kill_valid) begin
                    main_src = MAIN_FROM_SKID;
                end else if (acc) begin
                    main_src = MAIN_FROM_IN;
                end else begin
                    main_src = MAIN_CLEAR;
                end
                skid_clr = '1;
            end else if (kill_valid) begin
                skid_clr = '1;
            end else if (acc) begin
                skid_load = 1'b1;
            end
        end else begin
            if (acc) begin
                main_src = MAIN_FROM_IN;
            end else if (consumed) begin
                main_src = MAIN_CLEAR;
            end
        end
    end

    // Translate the selected source into main group register controls.
    always_comb begin
        main_load   = 1'b0;
        main_load_v = '0;
        main_load_d = in_data;
        main_clr    = '0;
        case (main_src)
            MAIN_HOLD:      main_clr = kmask;
            MAIN_FROM_SKID: begin
                main_load   = 1'b1;
                main_load_v = skid_v;
                main_load_d = skid_d;
            end
            MAIN_FROM_IN:   begin
                main_load   = 1'b1;
                main_load_v = in_valid;
                main_load_d = in_data;
            end
            MAIN_CLEAR:     main_clr = '1;
            default:        main_clr = '1;
        endcase
    end

    lane_group_reg #(
        .LANES (LANES),
        .WIDTH (WIDTH)
    ) u_main (
        .clk      (clk),
        .rst      (rst),
        .load     (main_load),
        .load_v   (main_load_v),
        .load_d   (main_load_d),
        .clr_mask (main_clr),
        .q_v      (main_v),
        .q_d      (main_d)
    );

    generate
        if (SKID != 0) begin : g_skid
            lane_group_reg #(
                .LANES (LANES),
                .WIDTH (WIDTH)
            ) u_skid (
                .clk      (clk),
                .rst      (rst),
                .load     (skid_load),
                .load_v   (in_valid),
                .load_d   (in_data),
                .clr_mask (skid_clr),
                .q_v      (skid_v),
                .q_d      (skid_d)
            );
        end else begin : g_no_skid
            assign skid_v = '0;
            assign skid_d = '0;
        end
    endgenerate

    // Counter increments for this cycle; a flush cycle counts nothing.
    always_comb begin
        stall_inc = |out_valid && !out_ready && !flush;
        kill_inc  = 0;
        if (!flush) begin
            kill_inc = popcount(main_v & kmask);
            if (kill_valid) kill_inc = kill_inc + popcount(skid_v);
        end
        kill_sum = {1'b0, kill_cnt} + (CNT_W+1)'(kill_inc);
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            kill_cnt  <= '0;
        end else begin
            if (stall_inc && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
            kill_cnt <= kill_sum[CNT_W] ? CNT_MAX : kill_sum[CNT_W-1:0];
        end
    end

endmodule
